// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller that feeds an external combinational ALU
// from a 4-entry register file and writes the captured result back.
module alu_sequencer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instr,
    input  logic              ld_en,
    output logic              ld_ready,
    input  logic [1:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [1:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_opc,
    input  logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              done
);

    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned INSTR_W  = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    logic [1:0]                         state_q,   state_d;
    logic [INSTR_W-1:0]                 instr_q,   instr_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q,    regs_d;
    logic [DATA_W-1:0]                  alu_a_q,   alu_a_d;
    logic [DATA_W-1:0]                  alu_b_q,   alu_b_d;
    logic [1:0]                         alu_opc_q, alu_opc_d;
    logic [DATA_W-1:0]                  result_q,  result_d;
    logic                               zero_q,    zero_d;

    // Status decoded purely from state; rd_data is a direct register-file read.
    assign instr_ready = (state_q == S_IDLE);
    assign ld_ready    = (state_q == S_IDLE);
    assign done        = (state_q == S_WB);
    assign rd_data     = regs_q[rd_addr];
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opc     = alu_opc_q;
    assign result      = result_q;
    assign zero        = zero_q;

    // Next-state and datapath update; loads and writeback live in disjoint states.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        regs_d    = regs_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_opc_d = alu_opc_q;
        result_d  = result_q;
        zero_d    = zero_q;
        case (state_q)
            S_IDLE: begin
                if (ld_en) begin
                    regs_d[ld_addr] = ld_data;
                end
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                alu_a_d   = regs_q[instr_q[3:2]];
                alu_b_d   = regs_q[instr_q[1:0]];
                alu_opc_d = instr_q[7:6];
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                result_d = alu_out;
                state_d  = S_WB;
            end
            S_WB: begin
                regs_d[instr_q[5:4]] = result_q;
                zero_d               = (result_q == '0);
                state_d              = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            regs_q    <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_opc_q <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            regs_q    <= regs_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_opc_q <= alu_opc_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: transaction-level reference model plus directed
// scenarios with literal expectations, then randomized traffic.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       instr_valid, instr_ready;
    logic [7:0] instr;
    logic       ld_en, ld_ready;
    logic [1:0] ld_addr, rd_addr;
    logic [7:0] ld_data, rd_data;
    logic [7:0] alu_a, alu_b, alu_out, result;
    logic [1:0] alu_opc;
    logic       zero, done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Reference ALU: 00 NAND, 01 NOR, 10 XOR, 11 ADD (wrapping).
    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return ~(a & b);
            2'd1:    return ~(a | b);
            2'd2:    return a ^ b;
            default: return 8'(a + b);
        endcase
    endfunction

    assign alu_out = alu_f(alu_opc, alu_a, alu_b);

    alu_sequencer #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .ld_en(ld_en), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opc(alu_opc), .alu_out(alu_out),
        .result(result), .zero(zero), .done(done)
    );

    // Model: register file plus one pending transaction and its age in cycles.
    logic [7:0] m_regs [4];
    int         m_age;
    logic [7:0] m_a, m_b, m_result;
    logic [1:0] m_opc;
    logic       m_zero;
    logic [1:0] p_opc, p_dst;
    logic [7:0] p_a, p_b, p_res;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_age = 0; m_a = 8'h00; m_b = 8'h00; m_opc = 2'd0;
        m_result = 8'h00; m_zero = 1'b0;
    endtask

    // Advance the model across the coming rising edge using the driven inputs.
    task automatic model_step();
        case (m_age)
            0: begin
                if (ld_en) m_regs[ld_addr] = ld_data;
                if (instr_valid) begin
                    p_opc = instr[7:6];
                    p_dst = instr[5:4];
                    p_a   = m_regs[instr[3:2]];
                    p_b   = m_regs[instr[1:0]];
                    p_res = alu_f(p_opc, p_a, p_b);
                    m_age = 1;
                end
            end
            1: begin m_a = p_a; m_b = p_b; m_opc = p_opc; m_age = 2; end
            2: begin m_result = p_res; m_age = 3; end
            default: begin
                m_regs[p_dst] = m_result;
                m_zero = (m_result == 8'h00);
                m_age = 0;
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("instr_ready", 8'(instr_ready), 8'(m_age == 0));
        chk("ld_ready",    8'(ld_ready),    8'(m_age == 0));
        chk("done",        8'(done),        8'(m_age == 3));
        chk("alu_a",       alu_a,           m_a);
        chk("alu_b",       alu_b,           m_b);
        chk("alu_opc",     8'(alu_opc),     8'(m_opc));
        chk("result",      result,          m_result);
        chk("zero",        8'(zero),        8'(m_zero));
        chk("rd_data",     rd_data,         m_regs[rd_addr]);
    endtask

    // One clock: compare at the falling edge, then drive inputs for the next rise.
    task automatic cycle(input logic v, input logic [7:0] ins, input logic le,
                         input logic [1:0] la, input logic [7:0] ld, input logic [1:0] ra);
        @(negedge clk);
        check_outputs();
        instr_valid = v; instr = ins; ld_en = le; ld_addr = la; ld_data = ld; rd_addr = ra;
        model_step();
    endtask

    task automatic nop(input logic [1:0] ra);
        cycle(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, ra);
    endtask

    task automatic load(input logic [1:0] la, input logic [7:0] ld);
        cycle(1'b0, 8'h00, 1'b1, la, ld, 2'd0);
    endtask

    // Issue one instruction from IDLE and sample EXEC opcode, WB result and post-WB state.
    task automatic exec_instr(input logic [7:0] ins, input logic le, input logic [1:0] la,
                              input logic [7:0] ld, input logic [1:0] ra,
                              output logic [1:0] opc_x, output logic [7:0] res_w,
                              output logic done_w, output logic [7:0] rd_w, output logic z_w);
        cycle(1'b1, ins, le, la, ld, ra);
        nop(ra);
        nop(ra); #1; opc_x = alu_opc;
        nop(ra); #1; res_w = result; done_w = done;
        nop(ra); #1; rd_w = rd_data; z_w = zero;
    endtask

    task automatic reset_checks();
        chk("rst_instr_ready", 8'(instr_ready), 8'd1);
        chk("rst_ld_ready",    8'(ld_ready),    8'd1);
        chk("rst_done",        8'(done),        8'd0);
        chk("rst_result",      result,          8'h00);
        chk("rst_zero",        8'(zero),        8'd0);
        chk("rst_alu_a",       alu_a,           8'h00);
        chk("rst_alu_b",       alu_b,           8'h00);
        chk("rst_alu_opc",     8'(alu_opc),     8'd0);
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            chk("rst_reg", rd_data, 8'h00);
        end
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [1:0] opc_x;
        logic [7:0] res_w, rd_w, ldv;
        logic       done_w, z_w;
        int         d1, d2;

        instr_valid = 1'b0; instr = 8'h00; ld_en = 1'b0; ld_addr = 2'd0;
        ld_data = 8'h00; rd_addr = 2'd0;
        #2 rst = 1'b1;
        #1 reset_checks();
        release_reset();

        // R2 = R0 + R1 = 0x0F + 0xF0
        load(2'd0, 8'h0F);
        load(2'd1, 8'hF0);
        exec_instr(8'hE1, 1'b0, 2'd0, 8'h00, 2'd2, opc_x, res_w, done_w, rd_w, z_w);
        chk("t1_opc_exec", 8'(opc_x), 8'd3);
        chk("t1_result",   res_w,     8'hFF);
        chk("t1_done",     8'(done_w), 8'd1);
        chk("t1_r2",       rd_w,      8'hFF);
        chk("t1_zero",     8'(z_w),   8'd0);

        // R3 = R0 ^ R0
        exec_instr(8'hB0, 1'b0, 2'd0, 8'h00, 2'd3, opc_x, res_w, done_w, rd_w, z_w);
        chk("t2_result", res_w,   8'h00);
        chk("t2_r3",     rd_w,    8'h00);
        chk("t2_zero",   8'(z_w), 8'd1);

        // R0 = 0xFF + 0x01 wraps to zero
        load(2'd0, 8'hFF);
        load(2'd1, 8'h01);
        exec_instr(8'hC1, 1'b0, 2'd0, 8'h00, 2'd0, opc_x, res_w, done_w, rd_w, z_w);
        chk("t3_result", res_w,   8'h00);
        chk("t3_r0",     rd_w,    8'h00);
        chk("t3_zero",   8'(z_w), 8'd1);

        // Load R1=0x05 on the accept edge of R2 = NAND(R1,R1)
        exec_instr(8'h25, 1'b1, 2'd1, 8'h05, 2'd2, opc_x, res_w, done_w, rd_w, z_w);
        chk("t4_result", res_w, 8'hFA);
        chk("t4_r2",     rd_w,  8'hFA);

        // Back-to-back with instr_valid held: R3=R1+R2 (0xFF), then R1=R3^R1 (0xFA);
        // a load to R0 while busy must be ignored.
        d1 = -1; d2 = -1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, (i == 0) ? 8'hF6 : 8'h9D, (i == 2), 2'd0, 8'h77, 2'd0);
            #1;
            if (done) begin
                if (d1 < 0) d1 = i; else d2 = i;
            end
        end
        chk("t5_first_done",  8'(d1),      8'd3);
        chk("t5_done_spacing", 8'(d2 - d1), 8'd4);
        nop(2'd0); #1; chk("t5_r0_ignored_load", rd_data, 8'h00);
        nop(2'd1); #1; chk("t5_r1", rd_data, 8'hFA);
        nop(2'd3); #1; chk("t5_r3", rd_data, 8'hFF);

        // Reset during EXEC of an ADD targeting R2=0x33
        load(2'd2, 8'h33);
        load(2'd0, 8'h11);
        load(2'd1, 8'h22);
        cycle(1'b1, 8'hE1, 1'b0, 2'd0, 8'h00, 2'd2);
        nop(2'd2);
        nop(2'd2); #1;
        chk("t6_opc_exec", 8'(alu_opc), 8'd3);
        rst = 1'b1;
        #1 reset_checks();
        release_reset();
        rd_addr = 2'd2;
        repeat (5) nop(2'd2);
        #1 chk("t6_r2_no_wb", rd_data, 8'h00);

        // Randomized traffic with operand values biased toward wrap and zero cases
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       ldv = 8'h00;
                1:       ldv = 8'hFF;
                2:       ldv = 8'h01;
                default: ldv = 8'($urandom);
            endcase
            cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0),
                  2'($urandom), ldv, 2'($urandom));
        end
        repeat (4) nop(2'd0);
        @(negedge clk);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control unit that drives the 2-bit-opcode ALU (00 NAND, 01 NOR, 10 XOR, 11 ADD, 8-bit A/B in, 8-bit out) from the other side.
- Accepts one packed instruction through a valid/ready handshake.
- Reads two operands from a 4-entry register file and presents them with the opcode on the ALU inputs.
- Captures the ALU result, writes it back to the register file and updates a zero flag.
- The ALU stays a separate combinational instance. This block owns only its inputs (alu_a, alu_b, alu_opc) and reads alu_out.

Parameters:
DATA_W, 8, operand/register/result width; must equal ALU width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
instr_valid  in  1  instruction offered.
instr_ready  out  1  block can accept an instruction.
instr  in  8  [7:6] opc, [5:4] dest reg, [3:2] srcA reg, [1:0] srcB reg.
ld_en  in  1  direct register load strobe.
ld_ready  out  1  load is accepted this cycle.
ld_addr  in  2  register to load.
ld_data  in  DATA_W  load value.
rd_addr  in  2  observation read address.
rd_data  out  DATA_W  combinational read of reg[rd_addr].
alu_a  out  DATA_W  registered operand A to ALU.
alu_b  out  DATA_W  registered operand B to ALU.
alu_opc  out  2  registered opcode to ALU.
alu_out  in  DATA_W  ALU result.
result  out  DATA_W  last captured result.
zero  out  1  last written-back result == 0.
done  out  1  one-cycle pulse, result valid.

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=IDLE.
  - reg[0..3]=0, instr_q=0, alu_a=0, alu_b=0, alu_opc=0, result=0, zero=0.
  - Any in-flight instruction is dropped with no writeback.
- States: IDLE -> READ -> EXEC -> WB -> IDLE. There are no other transitions.
- instr_ready = (state==IDLE). ld_ready = (state==IDLE). Both are decoded from state only and do not depend on any input.
- IDLE:
  - On an edge with instr_valid&&instr_ready: instr_q<=instr, go to READ.
  - Otherwise stay in IDLE.
- Load: an edge with ld_en&&ld_ready writes reg[ld_addr]<=ld_data. ld_en in any other state is ignored.
- Simultaneous load and instruction accept in IDLE:
  - Both take effect on the same edge.
  - The instruction's operands are read in READ, so they see the newly loaded value.
- READ, edge leaving it:
  - alu_a<=reg[instr_q[3:2]].
  - alu_b<=reg[instr_q[1:0]].
  - alu_opc<=instr_q[7:6].
  - Go to EXEC.
- EXEC:
  - The ALU is combinational, so alu_out is valid during this cycle.
  - Edge leaving EXEC: result<=alu_out, go to WB.
- WB:
  - done=1 for exactly this one cycle, with result already valid.
  - Edge leaving WB: reg[instr_q[5:4]]<=result, zero<=(result==0), go to IDLE.
- Timing: accept at edge E0; done high in the cycle after E2; the register-file write and instr_ready return occur at E3. Throughput is one instruction per 4 cycles.
- Arithmetic: ADD wraps modulo 2^DATA_W with no carry. The block does not interpret the operation; it only routes and captures.
- dest equal to a source (e.g. R0=R0+R0) is legal. Sources are sampled in READ, before the write in WB.
- instr_valid held high while not ready: no capture. The offered instruction is taken at the first IDLE edge.
- alu_a, alu_b and alu_opc hold their last values outside READ.
- rd_data reflects a write starting the cycle after the write edge.

Test Plan:
- Load R0=0x0F, R1=0xF0; issue instr {11,10,00,01} (R2=R0+R1) -> done one cycle after the third edge from accept, result=0xFF, rd_data(R2)=0xFF, zero=0, alu_opc=11 during EXEC.
- Issue {10,11,00,00} (R3=R0^R0) with R0=0x0F -> result=0x00, R3=0x00, zero=1.
- R0=0xFF, R1=0x01, ADD into R0 -> result=0x00 (wrap), R0=0x00, zero=1.
- Same IDLE edge: ld R1=0x05 and instr {00,10,01,01} (R2=NAND(R1,R1)) -> result=0xFA, R2=0xFA.
- Hold instr_valid high for 8 cycles with two back-to-back instructions -> instr_ready low in READ/EXEC/WB, second accepted on the first IDLE edge, done pulses exactly 4 cycles apart; ld_en during EXEC ignored (register unchanged).
- Assert rst during EXEC of an ADD targeting R2=0x33 -> immediately all regs=0, result=0, done=0, instr_ready=1, no writeback after rst release.
